// File: rtl/serializer.sv
// Parallel-to-serial transmit stage: LSB-first word output with a one-word holding
// buffer so that consecutive words leave back-to-back, and a last-bit flag for the receiver.
//
// state   | meaning
// S_IDLE  | nothing shifting; loads the held word on the next enabled edge
// S_SHIFT | word in shreg_q is going out, one bit per enabled edge
module serializer #(
  parameter int LENGTH = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [LENGTH-1:0] iv_din,
  input  logic              i_din_valid,
  output logic              o_din_ready,
  output logic              o_dout,
  output logic              o_dout_valid,
  output logic              o_dout_last,
  output logic              o_busy
);

  localparam int CW = (LENGTH > 2) ? $clog2(LENGTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LENGTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [LENGTH-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              ready_q, ready_d;
  logic [LENGTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              dout_last_q, dout_last_d;
  logic              accept;
  logic              drain;

  // The handshake runs on every edge; everything on the bit side waits for i_en.
  assign accept = i_din_valid & ready_q;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    drain        = 1'b0;

    if (i_en) begin
      if (state_q == S_IDLE) begin
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
        if (buf_full_q) begin
          shreg_d = buf_q;
          cnt_d   = '0;
          state_d = S_SHIFT;
          drain   = 1'b1;
        end
      end else begin
        dout_d       = shreg_q[0];
        dout_valid_d = 1'b1;
        dout_last_d  = (cnt_q == CNT_LAST);
        shreg_d      = shreg_q >> 1;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (buf_full_q) begin
            shreg_d = buf_q;
            drain   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    end

    // Accept and drain never coincide: ready is low whenever the buffer is full.
    buf_d      = accept ? iv_din : buf_q;
    buf_full_d = accept ? 1'b1 : (drain ? 1'b0 : buf_full_q);
    ready_d    = ~buf_full_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      ready_q      <= 1'b0;
      shreg_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      ready_q      <= ready_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
    end
  end

  assign o_din_ready  = ready_q;
  assign o_dout       = dout_q;
  assign o_dout_valid = dout_valid_q;
  assign o_dout_last  = dout_last_q;
  assign o_busy       = (state_q == S_SHIFT) | buf_full_q;

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: a receiver model shifts o_dout on every enabled edge
// and captures the word when o_dout_last is seen.
module tb_serializer;
  localparam int L = 24;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_en = 1'b1;
  logic [L-1:0] iv_din = '0;
  logic         i_din_valid = 1'b0;
  logic         o_din_ready, o_dout, o_dout_valid, o_dout_last, o_busy;

  serializer #(.LENGTH(L)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .iv_din(iv_din), .i_din_valid(i_din_valid), .o_din_ready(o_din_ready),
    .o_dout(o_dout), .o_dout_valid(o_dout_valid), .o_dout_last(o_dout_last),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int en_mode = 0;
  int cyc = 0;
  always @(negedge i_clk) begin
    cyc = cyc + 1;
    case (en_mode)
      0:       i_en = 1'b1;
      1:       i_en = (cyc % 3 == 0);
      default: i_en = 1'b0;
    endcase
  end

  // One entry per enabled edge, taken 1 time unit after the edge.
  bit           mon_v[$];
  bit           mon_d[$];
  bit           mon_l[$];
  logic [L-1:0] rx_q[$];
  logic [L-1:0] ds_sh = '0;
  logic [2:0]   prev_o = '0;
  logic         mon_en;
  int           hold_err = 0;

  always @(posedge i_clk) begin
    mon_en = i_en;
    #1;
    if (i_rst_n) begin
      if (mon_en) begin
        mon_v.push_back(o_dout_valid);
        mon_d.push_back(o_dout);
        mon_l.push_back(o_dout_last);
        ds_sh = {o_dout, ds_sh[L-1:1]};
        if (o_dout_last) rx_q.push_back(ds_sh);
      end else if ({o_dout, o_dout_valid, o_dout_last} != prev_o) begin
        hold_err = hold_err + 1;
      end
      prev_o = {o_dout, o_dout_valid, o_dout_last};
    end else begin
      prev_o = '0;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance with valid dropped.
  task automatic send(input logic [L-1:0] w, output int acc_n);
    logic r;
    bit   ok;
    ok = 0;
    acc_n = 0;
    iv_din = w;
    i_din_valid = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      r = o_din_ready;
      @(posedge i_clk);
      if (r) begin
        ok = 1;
        #2;
        acc_n = mon_v.size();
      end
      @(negedge i_clk);
    end
    i_din_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge i_clk);
      t++;
    end
    if (rx_q.size() < n) check("wait_rx_timeout", rx_q.size(), n);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Checks latency, bit count, contiguity and last-flag placement from index base on.
  task automatic check_burst(input string tag, input int base, input int acc_n, input int nbits);
    int f, nv, gaps, badl;
    bit exp_l;
    f = -1; nv = 0; gaps = 0; badl = 0;
    for (int i = base; i < mon_v.size(); i++) begin
      if (mon_v[i]) begin
        nv++;
        if (f < 0) f = i;
      end
    end
    if (f >= 0) begin
      for (int i = f; i < f + nbits; i++)
        if (i >= mon_v.size() || !mon_v[i]) gaps++;
    end
    for (int i = base; i < mon_l.size(); i++) begin
      exp_l = (f >= 0) && (i >= f) && (i < f + nbits) && ((i - f) % L == L - 1);
      if (mon_l[i] != exp_l) badl++;
    end
    check({tag, "_latency"}, f, acc_n + 1);
    check({tag, "_nvalid"}, nv, nbits);
    check({tag, "_gaps"}, gaps, 0);
    check({tag, "_last_pos"}, badl, 0);
  endtask

  logic [L-1:0] words[13];
  int           a0, a1, base, rb, nv, he;
  logic [7:0]   byte0;

  initial begin
    // Reset, then idle with i_en=1
    run(3);
    check("rst_outputs", {o_din_ready, o_dout, o_dout_valid, o_dout_last, o_busy}, 5'b0);
    i_rst_n = 1'b1;
    base = mon_v.size();
    @(posedge i_clk); #1;
    check("ready_after_release", o_din_ready, 1'b1);
    run(6);
    nv = 0;
    for (int i = base; i < mon_v.size(); i++) if (mon_v[i]) nv++;
    check("idle_no_valid", nv, 0);
    check("idle_busy", o_busy, 1'b0);

    // Single word
    base = mon_v.size(); rb = rx_q.size();
    send(24'hA5C3F1, a0);
    wait_rx(rb + 1, 100);
    run(4);
    check_burst("single", base, a0, 24);
    byte0 = '0;
    for (int i = 0; i < 8; i++)
      if (a0 + 1 + i < mon_d.size()) byte0[i] = mon_d[a0 + 1 + i];
    check("single_low_byte", byte0, 8'hF1);
    check("single_word", rx_q.size() > rb ? rx_q[rb] : 24'h0, 24'hA5C3F1);

    // Back-to-back
    base = mon_v.size(); rb = rx_q.size();
    send(24'h000001, a0);
    send(24'h800000, a1);
    wait_rx(rb + 2, 200);
    run(4);
    check_burst("b2b", base, a0, 48);
    check("b2b_word0", rx_q.size() > rb ? rx_q[rb] : 24'hx, 24'h000001);
    check("b2b_word1", rx_q.size() > rb + 1 ? rx_q[rb + 1] : 24'hx, 24'h800000);

    // Same traffic with i_en every third cycle
    en_mode = 1;
    run(3);
    base = mon_v.size(); rb = rx_q.size(); he = hold_err;
    send(24'h000001, a0);
    send(24'h800000, a1);
    wait_rx(rb + 2, 600);
    run(8);
    check_burst("div3", base, a0, 48);
    check("div3_word0", rx_q.size() > rb ? rx_q[rb] : 24'hx, 24'h000001);
    check("div3_word1", rx_q.size() > rb + 1 ? rx_q[rb + 1] : 24'hx, 24'h800000);
    check("div3_hold", hold_err - he, 0);

    // Source holds valid while ready=0
    en_mode = 2;
    run(3);
    base = mon_v.size(); rb = rx_q.size();
    send(24'h5A5A5A, a0);
    iv_din = 24'h123456;
    i_din_valid = 1'b1;
    run(6);
    check("stall_ready_low", o_din_ready, 1'b0);
    check("stall_busy", o_busy, 1'b1);
    en_mode = 0;
    send(24'h123456, a1);
    wait_rx(rb + 2, 200);
    run(30);
    check_burst("stall", base, a0, 48);
    check("stall_rx_count", rx_q.size() - rb, 2);
    check("stall_word0", rx_q.size() > rb ? rx_q[rb] : 24'hx, 24'h5A5A5A);
    check("stall_word1", rx_q.size() > rb + 1 ? rx_q[rb + 1] : 24'hx, 24'h123456);

    // Loopback with random words and reset in the middle of word 12
    rb = rx_q.size();
    for (int k = 0; k < 13; k++) words[k] = L'($urandom);
    for (int k = 0; k < 12; k++) send(words[k], a0);
    wait_rx(rb + 11, 400);
    run(10);
    @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst_outputs", {o_din_ready, o_dout, o_dout_valid, o_dout_last, o_busy}, 5'b0);
    run(2);
    i_rst_n = 1'b1;
    run(30);
    check("midrst_rx_count", rx_q.size() - rb, 11);
    check("midrst_busy", o_busy, 1'b0);
    for (int k = 0; k < 11; k++)
      check($sformatf("loop_word%0d", k), rx_q.size() > rb + k ? rx_q[rb + k] : 24'hx, words[k]);
    send(words[12], a0);
    wait_rx(rb + 12, 100);
    check("post_rst_word", rx_q.size() > rb + 11 ? rx_q[rb + 11] : 24'hx, words[12]);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
